// File: rtl/regfile_wb_arbiter.sv
`timescale 1ns/1ps
// Register-file writeback arbiter.
// Merges the single-cycle ALU writeback stream (buffered by a 2-entry FIFO
// with an empty-FIFO bypass) and the multiply/divide writeback stream onto
// one registered register-file write port. Round-robin on contention.
// Also keeps a busy scoreboard of long-latency destinations so decode can
// detect hazards on its source registers.
module regfile_wb_arbiter (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        alu_we,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic [4:0]  rs_a,
  input  logic [4:0]  rs_b,
  output logic        hazard,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        overflow
);

  // FIFO storage: entry 0 is always the head
  logic [1:0]  count;
  logic [4:0]  q0_rd;
  logic [31:0] q0_data;
  logic [4:0]  q1_rd;
  logic [31:0] q1_data;

  // 1 = MD side was granted most recently, so ALU wins the next contention
  logic        last_md;
  logic [31:0] busy;
  logic [31:0] busy_next;

  logic        alu_in_ok;
  logic        fifo_empty;
  logic        alu_cand;
  logic [4:0]  alu_cand_rd;
  logic [31:0] alu_cand_data;
  logic        md_cand;
  logic        grant_alu;
  logic        grant_md;
  logic        pop;
  logic        bypass_taken;
  logic        push_req;
  logic        push;
  logic        drop;

  // Candidate selection and one-grant-per-cycle arbitration
  always_comb begin
    alu_in_ok     = alu_we && (alu_rd != 5'd0);
    fifo_empty    = (count == 2'd0);
    alu_cand      = !fifo_empty || alu_in_ok;
    alu_cand_rd   = fifo_empty ? alu_rd : q0_rd;
    alu_cand_data = fifo_empty ? alu_data : q0_data;
    md_cand       = md_valid && (md_rd != 5'd0);
    grant_alu     = alu_cand && (!md_cand || last_md);
    grant_md      = md_cand && !grant_alu;
    // Writes to r0 are acknowledged but never reach the register file
    md_ready      = md_valid && ((md_rd == 5'd0) || grant_md);
    alu_stall     = (count == 2'd2);
  end

  // FIFO push/pop decisions; an incoming write only skips the FIFO when it is
  // the bypass candidate and actually wins this cycle
  always_comb begin
    pop          = !fifo_empty && grant_alu;
    bypass_taken = fifo_empty && grant_alu;
    push_req     = alu_in_ok && !bypass_taken;
    push         = push_req && ((count != 2'd2) || pop);
    drop         = push_req && !push;
  end

  // FIFO storage and occupancy
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      count   <= 2'd0;
      q0_rd   <= 5'd0;
      q0_data <= 32'd0;
      q1_rd   <= 5'd0;
      q1_data <= 32'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            q0_rd   <= alu_rd;
            q0_data <= alu_data;
          end else begin
            q1_rd   <= alu_rd;
            q1_data <= alu_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          q0_rd   <= q1_rd;
          q0_data <= q1_data;
          count   <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q0_rd   <= alu_rd;
            q0_data <= alu_data;
          end else begin
            q0_rd   <= q1_rd;
            q0_data <= q1_data;
            q1_rd   <= alu_rd;
            q1_data <= alu_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Round-robin pointer; only moves on a real grant
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset)
      last_md <= 1'b1;
    else if (grant_alu)
      last_md <= 1'b0;
    else if (grant_md)
      last_md <= 1'b1;
  end

  // Scoreboard update: MD completion clears, new issue sets (set wins), r0 never busy
  always_comb begin
    busy_next = busy;
    if (grant_md)
      busy_next[md_rd] = 1'b0;
    if (md_issue && (md_issue_rd != 5'd0))
      busy_next[md_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset)
      busy <= 32'd0;
    else
      busy <= busy_next;
  end

  // Registered register-file write port; address/data hold when idle
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      rf_we <= grant_alu || grant_md;
      if (grant_alu) begin
        rf_waddr <= alu_cand_rd;
        rf_wdata <= alu_cand_data;
      end else if (grant_md) begin
        rf_waddr <= md_rd;
        rf_wdata <= md_data;
      end
    end
  end

  // Sticky flag for ALU writes lost to a full FIFO
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
  end

  function automatic logic src_pending(input logic [4:0] src);
    logic hit;
    hit = 1'b0;
    if (src != 5'd0) begin
      if (busy[src])                                 hit = 1'b1;
      if ((count != 2'd0) && (q0_rd == src))         hit = 1'b1;
      if ((count == 2'd2) && (q1_rd == src))         hit = 1'b1;
      if (rf_we && (rf_waddr == src))                hit = 1'b1;
      if (alu_we && (alu_rd == src))                 hit = 1'b1;
    end
    return hit;
  endfunction

  // Decode hazard: any source with a write not yet committed
  always_comb begin
    hazard = src_pending(rs_a) || src_pending(rs_b);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_regfile_wb_arbiter;

  logic        clock;
  logic        ctrl_reset;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic [4:0]  rs_a;
  logic [4:0]  rs_b;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .rs_a(rs_a), .rs_b(rs_b), .hazard(hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .overflow(overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  int          m_qrd[$];
  logic [31:0] m_qdat[$];
  bit   [31:0] m_busy;
  bit          m_last_md;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_ovf;

  task automatic m_reset();
    m_qrd.delete();
    m_qdat.delete();
    m_busy    = 0;
    m_last_md = 1;
    m_we      = 0;
    m_waddr   = 0;
    m_wdata   = 0;
    m_ovf     = 0;
  endtask

  task automatic m_arb(output bit ga, output bit gm);
    bit alu_has, md_has;
    alu_has = (m_qrd.size() > 0) || (alu_we && alu_rd != 0);
    md_has  = md_valid && md_rd != 0;
    ga = alu_has && (!md_has || m_last_md);
    gm = md_has && !ga;
  endtask

  function automatic bit m_hit(input logic [4:0] s);
    if (s == 0) return 0;
    if (m_busy[s]) return 1;
    foreach (m_qrd[i]) if (m_qrd[i] == s) return 1;
    if (m_we && m_waddr == s) return 1;
    if (alu_we && alu_rd == s) return 1;
    return 0;
  endfunction

  task automatic m_step();
    bit ga, gm, was_empty;
    m_arb(ga, gm);
    was_empty = (m_qrd.size() == 0);
    m_we = ga || gm;
    if (ga) begin
      if (was_empty) begin
        m_waddr = alu_rd; m_wdata = alu_data;
      end else begin
        m_waddr = m_qrd.pop_front(); m_wdata = m_qdat.pop_front();
      end
      m_last_md = 0;
    end else if (gm) begin
      m_waddr = md_rd; m_wdata = md_data;
      m_busy[md_rd] = 0;
      m_last_md = 1;
    end
    if (alu_we && alu_rd != 0 && !(was_empty && ga)) begin
      if (m_qrd.size() < 2) begin
        m_qrd.push_back(alu_rd); m_qdat.push_back(alu_data);
      end else
        m_ovf = 1;
    end
    if (md_issue && md_issue_rd != 0) m_busy[md_issue_rd] = 1;
  endtask

  // ---------------- stimulus utilities ----------------
  task automatic idle();
    alu_we = 0; alu_rd = 0; alu_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
    md_issue = 0; md_issue_rd = 0; rs_a = 0; rs_b = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle();
    ctrl_reset = 1;
    @(negedge clock);
    ctrl_reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clock);
    idle();
    ctrl_reset = 1;
    #1;
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_rf_we: got %0b expected 0", rf_we); end
    n_tests++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b expected 0", alu_stall); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL rst_hazard: got %0b expected 0", hazard); end
    md_valid = 1; md_rd = 3;
    #1;
    n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL rst_md_ready_alone: got %0b expected 1", md_ready); end
    alu_we = 1; alu_rd = 3; rs_a = 3;
    #1;
    n_tests++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL rst_md_ready_contend: got %0b expected 0", md_ready); end
    n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL rst_hazard_incoming: got %0b expected 1", hazard); end
    tick();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_no_write: got %0b expected 0", rf_we); end
    idle();
    @(negedge clock);
    ctrl_reset = 0;
  endtask

  task automatic test_bypass();
    do_reset();
    alu_we = 1; alu_rd = 5; alu_data = 32'h11;
    tick();
    alu_we = 0;
    n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL bypass_we: got %0b expected 1", rf_we); end
    n_tests++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL bypass_addr: got %0d expected 5", rf_waddr); end
    n_tests++; if (rf_wdata !== 32'h11) begin n_fail++; $display("FAIL bypass_data: got %0h expected 11", rf_wdata); end
    tick();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL bypass_fifo_empty: got %0b expected 0", rf_we); end
    n_tests++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL bypass_addr_hold: got %0d expected 5", rf_waddr); end
  endtask

  task automatic test_contention();
    do_reset();
    alu_we = 1; alu_rd = 3; alu_data = 32'hA3;
    md_valid = 1; md_rd = 7; md_data = 32'hB7;
    #1;
    n_tests++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL cont_ready0: got %0b expected 0", md_ready); end
    tick();
    alu_we = 0;
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA3) begin
      n_fail++; $display("FAIL cont_first: got we=%0b addr=%0d data=%0h expected we=1 addr=3 data=a3", rf_we, rf_waddr, rf_wdata); end
    #1;
    n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL cont_ready1: got %0b expected 1", md_ready); end
    tick();
    md_valid = 0;
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hB7) begin
      n_fail++; $display("FAIL cont_second: got we=%0b addr=%0d data=%0h expected we=1 addr=7 data=b7", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_hazard();
    do_reset();
    md_issue = 1; md_issue_rd = 9; rs_a = 9;
    #1;
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL haz_before_issue: got %0b expected 0", hazard); end
    tick();
    md_issue = 0;
    #1;
    n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL haz_busy: got %0b expected 1", hazard); end
    md_valid = 1; md_rd = 9; md_data = 32'h99;
    #1;
    n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL haz_md_ready: got %0b expected 1", md_ready); end
    tick();
    md_valid = 0;
    #1;
    n_tests++; if (hazard !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
      n_fail++; $display("FAIL haz_inflight: got haz=%0b we=%0b addr=%0d expected haz=1 we=1 addr=9", hazard, rf_we, rf_waddr); end
    tick();
    n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL haz_cleared: got %0b expected 0", hazard); end
  endtask

  task automatic test_overflow();
    logic [4:0] exp_addr [6];
    bit         exp_stall [6];
    bit         exp_ovf [6];
    exp_addr  = '{5'd4, 5'd12, 5'd4, 5'd12, 5'd4, 5'd12};
    exp_stall = '{0, 0, 0, 0, 1, 1};
    exp_ovf   = '{0, 0, 0, 0, 0, 1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      alu_we = 1; alu_rd = 4; alu_data = 32'h400 + c;
      md_valid = 1; md_rd = 12; md_data = 32'hC00 + c;
      #1;
      n_tests++; if (alu_stall !== exp_stall[c]) begin n_fail++; $display("FAIL ovf_stall[%0d]: got %0b expected %0b", c, alu_stall, exp_stall[c]); end
      tick();
      n_tests++; if (rf_we !== 1'b1 || rf_waddr !== exp_addr[c]) begin
        n_fail++; $display("FAIL ovf_grant[%0d]: got we=%0b addr=%0d expected we=1 addr=%0d", c, rf_we, rf_waddr, exp_addr[c]); end
      n_tests++; if (overflow !== exp_ovf[c]) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %0b expected %0b", c, overflow, exp_ovf[c]); end
    end
    idle();
    tick(); tick(); tick();
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    alu_we = 1; alu_rd = 0; alu_data = 32'hDEAD;
    md_valid = 1; md_rd = 0; md_data = 32'hBEEF;
    #1;
    n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_md_ready: got %0b expected 1", md_ready); end
    tick();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_no_write: got %0b expected 0", rf_we); end
    alu_rd = 3; md_rd = 7;
    #1;
    n_tests++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL rd0_rr_unchanged: got %0b expected 0", md_ready); end
    tick();
    idle();
    n_tests++; if (rf_waddr !== 5'd3) begin n_fail++; $display("FAIL rd0_alu_first: got %0d expected 3", rf_waddr); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      alu_we = 1; alu_rd = 4; alu_data = c;
      md_valid = 1; md_rd = 12; md_data = c;
      md_issue = (c == 0); md_issue_rd = 9;
      tick();
    end
    idle();
    rs_a = 9; rs_b = 4;
    #1;
    n_tests++; if (alu_stall !== 1'b1 || overflow !== 1'b1 || hazard !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup: got stall=%0b ovf=%0b haz=%0b expected 1 1 1", alu_stall, overflow, hazard); end
    #2;
    ctrl_reset = 1;
    #1;
    n_tests++; if (alu_stall !== 1'b0 || rf_we !== 1'b0 || overflow !== 1'b0 || hazard !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got stall=%0b we=%0b ovf=%0b haz=%0b expected all 0", alu_stall, rf_we, overflow, hazard); end
    @(negedge clock);
    ctrl_reset = 0;
    tick();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_fifo_flushed: got %0b expected 0", rf_we); end
  endtask

  task automatic test_random();
    bit ga, gm, e_ready, e_stall, e_haz, hold_md;
    do_reset();
    m_reset();
    hold_md = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (!hold_md) begin
        md_valid = ($urandom % 2) == 1;
        md_rd    = 5'($urandom % 8);
        md_data  = $urandom;
      end
      alu_we      = (m_qrd.size() == 2) ? (($urandom % 8) == 0) : (($urandom % 3) != 0);
      alu_rd      = 5'($urandom % 8);
      alu_data    = $urandom;
      md_issue    = ($urandom % 4) == 0;
      md_issue_rd = 5'($urandom % 8);
      rs_a        = 5'($urandom % 10);
      rs_b        = 5'($urandom % 10);
      #1;
      m_arb(ga, gm);
      e_ready = md_valid && (md_rd == 0 || gm);
      e_stall = (m_qrd.size() == 2);
      e_haz   = m_hit(rs_a) || m_hit(rs_b);
      n_tests++; if (md_ready !== e_ready) begin n_fail++; $display("FAIL rnd_md_ready[%0d]: got %0b expected %0b", c, md_ready, e_ready); end
      n_tests++; if (alu_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0b expected %0b", c, alu_stall, e_stall); end
      n_tests++; if (hazard !== e_haz) begin n_fail++; $display("FAIL rnd_hazard[%0d]: got %0b expected %0b", c, hazard, e_haz); end
      hold_md = md_valid && !e_ready;
      @(posedge clock);
      m_step();
      #1;
      n_tests++; if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        n_fail++; $display("FAIL rnd_write[%0d]: got we=%0b addr=%0d data=%0h expected we=%0b addr=%0d data=%0h",
                           c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow[%0d]: got %0b expected %0b", c, overflow, m_ovf); end
    end
    idle();
  endtask

  initial begin
    ctrl_reset = 1;
    idle();
    #12;
    test_reset();
    test_bypass();
    test_contention();
    test_hazard();
    test_overflow();
    test_rd_zero();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL: clock  in  1  rising-edge clock for all state.
REQ-002 SHALL: ctrl_reset  in  1  reset, asynchronous, active-high.
REQ-003 SHALL: alu_we / alu_rd / alu_data  in  1/5/32  ALU writeback request; no backpressure beyond alu_stall.
REQ-004 SHALL: alu_stall  out  1  ALU FIFO full; pipeline holds alu_we low while high.
REQ-005 SHALL: md_valid / md_rd / md_data  in  1/5/32  mult/div writeback request, held until accepted.
REQ-006 SHALL: md_ready  out  1  MD request accepted this cycle (combinational).
REQ-007 SHALL: md_issue / md_issue_rd  in  1/5  long-latency op issued; mark destination busy.
REQ-008 SHALL: rs_a / rs_b  in  5/5  decode-stage source registers.
REQ-009 SHALL: hazard  out  1  a source has an uncommitted pending write (combinational).
REQ-010 SHALL: rf_we / rf_waddr / rf_wdata  out  1/5/32  registered write port to register file.
REQ-011 SHALL: overflow  out  1  sticky: ALU write dropped.

Function
REQ-012 SHALL: ALU path = 2-entry FIFO; ALU candidate = FIFO head, or incoming alu_we directly when FIFO empty (bypass).
REQ-013 SHALL: alu_we with alu_rd=0 discarded: not enqueued, not a candidate.
REQ-014 SHALL: MD candidate = md_valid with md_rd!=0; md_valid with md_rd=0 gets md_ready=1, no write, no arbitration effect.
REQ-015 SHALL: one grant per cycle; single candidate wins; both present -> round-robin via last_grant bit, winner = side not last granted; last_grant updates only on a real grant.
REQ-016 SHALL: granted request registered into rf_we/rf_waddr/rf_wdata next edge; no grant -> rf_we=0 next edge, rf_waddr/rf_wdata hold.
REQ-017 SHALL: latency alu_we -> rf_we = 1 cycle when bypass granted; md_valid&md_ready -> rf_we = 1 cycle.
REQ-018 SHALL: bypass candidate not granted -> enqueued; head granted and alu_we same cycle -> pop and push both occur, count unchanged.
REQ-019 SHALL: alu_stall = (count==2); alu_we with count==2 and no pop -> write dropped, overflow set until reset.
REQ-020 SHALL: scoreboard busy[31:0]; md_issue with md_issue_rd!=0 sets busy[md_issue_rd]; MD grant clears busy[md_rd]; same register set and clear in same cycle -> set wins; busy[0] always 0.
REQ-021 SHALL: hazard = for rs_a or rs_b nonzero: busy bit set, OR matches valid FIFO entry rd, OR matches rf_waddr while rf_we=1, OR matches rd of incoming alu_we.
REQ-022 SHALL: rf_we never asserted with rf_waddr=0.

Reset
REQ-023 SHALL: ctrl_reset asynchronously clears rf_we, rf_waddr, rf_wdata, FIFO count, busy[], overflow; last_grant=MD (ALU wins first contention).
REQ-024 SHALL: during and after reset, alu_stall=0, md_ready=md_valid&&(md_rd==0 || no ALU candidate), hazard=0 unless an incoming alu_we matches; in-flight requests lost, no write emitted from reset assertion onward.

Verification
REQ-025 SHALL: alu_we=1, alu_rd=5, alu_data=0x11, FIFO empty, no MD -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x11; count stays 0.
REQ-026 SHALL: after reset, alu_we (rd=3) and md_valid (rd=7) same cycle -> ALU granted, md_ready=0; next cycle MD granted, md_ready=1; rf writes r3 then r7.
REQ-027 SHALL: md_issue rd=9 -> rs_a=9 gives hazard=1; md_valid rd=9 granted -> busy[9] cleared; hazard=1 while rf_we=1, rf_waddr=9; hazard=0 following cycle.
REQ-028 SHALL: md_valid held high, alu_we every cycle rd=4 -> grants alternate, count reaches 2, alu_stall=1; alu_we ignored while stall and no pop -> overflow=1.
REQ-029 SHALL: alu_we rd=0 and md_valid rd=0 -> rf_we stays 0, md_ready=1, last_grant unchanged.
REQ-030 SHALL: ctrl_reset mid-stream with count=2, busy[9]=1 -> immediately count=0, busy=0, rf_we=0, overflow=0, hazard=0 with idle inputs.
